// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_e      : controller state (run / waiting on data memory)
//   pipe_ctrl_t  : bundle of the six pipeline control outputs
//   CTRL_RUN     : control bundle for normal, hazard-free operation
//   has_flush()  : true when any flush in a control bundle is asserted
package hazard_pkg;

  typedef enum logic [0:0] {
    StRun,
    StMemWait
  } state_e;

  localparam int unsigned ZERO_REG = 0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic freeze;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_write:    1'b1,
    ifid_write:  1'b1,
    ifid_flush:  1'b0,
    idex_flush:  1'b0,
    exmem_flush: 1'b0,
    freeze:      1'b0
  };

  // A load-use bubble also raises idex_flush, so callers decide whether it counts.
  function automatic logic has_flush(input pipe_ctrl_t c);
    return c.ifid_flush | c.idex_flush | c.exmem_flush;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status in, stall/flush controls and debug counters out.
//   master : pipeline side, drives the hazard status fields
//   slave  : controller side, drives the control enables and counters
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);

  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic              ex_memread;
  logic [REG_AW-1:0] ex_rt;
  logic              id_jump;
  logic              mem_branch_taken;
  logic              mem_ready;

  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_flush;
  logic              exmem_flush;
  logic              freeze;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, id_jump, mem_branch_taken, mem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, freeze,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, id_jump, mem_branch_taken, mem_ready,
    output pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, freeze,
    output stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   clear : synchronous clear, dominates inc
//   inc   : add one unless already at all-ones
//   count : current value
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of hazard_ctrl_if
//              in  : ID register fields, EX load info, ID jump, MEM branch taken, mem_ready
//              out : pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, freeze,
//                    stall_cnt, flush_cnt
// Controls are decoded combinationally; priority is memory freeze, taken branch, load-use,
// jump. The state register only tracks an outstanding memory access for debug visibility.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam logic [REG_AW-1:0] ZeroAddr = REG_AW'(ZERO_REG);

  state_e     state_q, state_d;
  pipe_ctrl_t ctrl;
  logic       load_use;
  logic       stall_inc;
  logic       flush_inc;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // $0 is hard-wired zero, so a load "into" it never creates a dependency.
  assign load_use = bus.ex_memread && (bus.ex_rt != ZeroAddr) &&
                    ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  always_comb begin
    state_d   = state_q;
    ctrl      = CTRL_RUN;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    unique case (state_q)
      StRun:     if (!bus.mem_ready) state_d = StMemWait;
      StMemWait: if (bus.mem_ready)  state_d = StRun;
      default:   state_d = StRun;
    endcase

    if (rst) begin
      state_d = StRun;
    end else if (!bus.mem_ready) begin
      // Whole pipeline holds, so any pending hazard is re-evaluated once memory is done.
      ctrl.freeze     = 1'b1;
      ctrl.pc_write   = 1'b0;
      ctrl.ifid_write = 1'b0;
      stall_inc       = 1'b1;
    end else if (bus.mem_branch_taken) begin
      // Younger load-use or jump instructions are being squashed anyway.
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.exmem_flush = 1'b1;
      flush_inc        = 1'b1;
    end else if (load_use) begin
      // Bubble into ID/EX; counts as a stall even though idex_flush is raised.
      ctrl.pc_write   = 1'b0;
      ctrl.ifid_write = 1'b0;
      ctrl.idex_flush = 1'b1;
      stall_inc       = 1'b1;
    end else if (bus.id_jump) begin
      ctrl.ifid_flush = 1'b1;
      flush_inc       = has_flush(ctrl);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  assign bus.pc_write    = ctrl.pc_write;
  assign bus.ifid_write  = ctrl.ifid_write;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_flush  = ctrl.idex_flush;
  assign bus.exmem_flush = ctrl.exmem_flush;
  assign bus.freeze      = ctrl.freeze;
  assign bus.stall_cnt   = stall_cnt;
  assign bus.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (16-bit and 2-bit counters) share stimulus;
// a reference model pushes expectations per cycle and a monitor compares at the falling edge.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus_a ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(2))  bus_b ();

  assign bus_b.id_rs            = bus_a.id_rs;
  assign bus_b.id_rt            = bus_a.id_rt;
  assign bus_b.id_uses_rt       = bus_a.id_uses_rt;
  assign bus_b.ex_memread       = bus_a.ex_memread;
  assign bus_b.ex_rt            = bus_a.ex_rt;
  assign bus_b.id_jump          = bus_a.id_jump;
  assign bus_b.mem_branch_taken = bus_a.mem_branch_taken;
  assign bus_b.mem_ready        = bus_a.mem_ready;

  hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  hazard_ctrl #(.REG_AW(5), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    logic [5:0] ctrl;   // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, freeze}
    int         stall_a;
    int         flush_a;
    int         stall_b;
    int         flush_b;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   stim_done = 1'b0;

  // Model counters; -1 means "not yet defined" (before the first reset edge).
  int m_stall_a = -1, m_flush_a = -1, m_stall_b = -1, m_flush_b = -1;

  function automatic int sat_add(input int v, input bit inc, input int lim);
    if (v < 0) return v;
    if (inc && v < lim) return v + 1;
    return v;
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Apply one cycle of stimulus and record what the spec says must come out.
  task automatic drive(input bit r, input int rs, input int rt, input bit uses_rt,
                       input bit memread, input int ert, input bit jump, input bit br,
                       input bit ready);
    exp_t e;
    bit   lu, stall_ev, flush_ev;
    @(posedge clk);
    #1;
    rst                    = r;
    bus_a.id_rs            = 5'(rs);
    bus_a.id_rt            = 5'(rt);
    bus_a.id_uses_rt       = uses_rt;
    bus_a.ex_memread       = memread;
    bus_a.ex_rt            = 5'(ert);
    bus_a.id_jump          = jump;
    bus_a.mem_branch_taken = br;
    bus_a.mem_ready        = ready;

    lu = memread && ert != 0 && (ert == rs || (uses_rt && ert == rt));
    stall_ev = 0;
    flush_ev = 0;
    if (r)          e.ctrl = 6'b110000;
    else if (!ready) begin e.ctrl = 6'b000001; stall_ev = 1; end
    else if (br)     begin e.ctrl = 6'b111110; flush_ev = 1; end
    else if (lu)     begin e.ctrl = 6'b000100; stall_ev = 1; end
    else if (jump)   begin e.ctrl = 6'b111000; flush_ev = 1; end
    else             e.ctrl = 6'b110000;

    e.stall_a = m_stall_a;
    e.flush_a = m_flush_a;
    e.stall_b = m_stall_b;
    e.flush_b = m_flush_b;
    exp_q.push_back(e);

    if (r) begin
      m_stall_a = 0; m_flush_a = 0; m_stall_b = 0; m_flush_b = 0;
    end else begin
      m_stall_a = sat_add(m_stall_a, stall_ev, 65535);
      m_flush_a = sat_add(m_flush_a, flush_ev, 65535);
      m_stall_b = sat_add(m_stall_b, stall_ev, 3);
      m_flush_b = sat_add(m_flush_b, flush_ev, 3);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [5:0] got_a, got_b;
      e = exp_q.pop_front();
      got_a = {bus_a.pc_write, bus_a.ifid_write, bus_a.ifid_flush, bus_a.idex_flush,
               bus_a.exmem_flush, bus_a.freeze};
      got_b = {bus_b.pc_write, bus_b.ifid_write, bus_b.ifid_flush, bus_b.idex_flush,
               bus_b.exmem_flush, bus_b.freeze};
      check("ctrl_a", int'(got_a), int'(e.ctrl));
      check("ctrl_b", int'(got_b), int'(e.ctrl));
      if (e.stall_a >= 0) begin
        check("stall_cnt_a", int'(bus_a.stall_cnt), e.stall_a);
        check("flush_cnt_a", int'(bus_a.flush_cnt), e.flush_a);
        check("stall_cnt_b", int'(bus_b.stall_cnt), e.stall_b);
        check("flush_cnt_b", int'(bus_b.flush_cnt), e.flush_b);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus_a.id_rs = '0; bus_a.id_rt = '0; bus_a.id_uses_rt = 0; bus_a.ex_memread = 0;
    bus_a.ex_rt = '0; bus_a.id_jump = 0; bus_a.mem_branch_taken = 0; bus_a.mem_ready = 1;

    //     rst rs rt ur mr ert jmp br rdy
    drive(1,  0, 0, 0, 0, 0,  0,  0, 1);
    drive(1,  0, 0, 0, 0, 0,  0,  0, 1);
    drive(0,  1, 2, 1, 0, 0,  0,  0, 1);   // idle after reset
    drive(0,  8, 3, 0, 1, 8,  0,  0, 1);   // load-use on rs
    drive(0,  8, 3, 0, 0, 0,  0,  0, 1);   // bubble has reached EX
    drive(0,  0, 0, 1, 1, 0,  0,  0, 1);   // load into $0: no hazard
    drive(0,  4, 9, 1, 1, 9,  0,  0, 1);   // load-use on rt
    drive(0,  4, 9, 0, 1, 9,  0,  0, 1);   // rt not read: no hazard
    drive(0,  5, 1, 0, 1, 5,  1,  1, 1);   // branch beats load-use and jump
    drive(0,  0, 0, 0, 0, 0,  0,  0, 0);   // freeze x3
    drive(0,  0, 0, 0, 1, 7,  1,  1, 0);
    drive(0,  7, 0, 0, 1, 7,  1,  0, 0);
    drive(0,  0, 0, 0, 0, 0,  1,  0, 1);   // release with jump
    drive(0,  6, 6, 1, 1, 6,  1,  0, 1);   // load-use beats jump
    drive(0,  6, 6, 1, 0, 0,  1,  0, 1);   // jump follows
    for (int i = 0; i < 5; i++) drive(0, 3, 0, 0, 1, 3, 0, 0, 1);
    drive(0,  0, 0, 0, 0, 0,  0,  0, 0);
    drive(1,  0, 0, 0, 0, 0,  0,  0, 0);   // reset during memory wait
    drive(0,  0, 0, 0, 0, 0,  0,  0, 0);   // freeze follows mem_ready
    drive(0,  0, 0, 0, 0, 0,  0,  0, 1);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(63) == 0), $urandom_range(3), $urandom_range(3),
            1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(3),
            ($urandom_range(3) == 0), ($urandom_range(5) == 0), ($urandom_range(3) != 0));
    end

    stim_done = 1'b1;
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: stim_done=%0d, expected 1", stim_done);
    $fatal(1, "timeout");
  end

endmodule
